// File: rtl/ctrl_store_buf_if.sv
// Bus bundle between the MEM stage / ctrl_mem side and the posted-store buffer.
interface ctrl_store_buf_if;
  logic        rdy;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_length;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        rd_pending;
  logic        ram_busy;
  logic        ram_write;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;
  logic [2:0]  ram_length;
  logic        ram_ready;
  logic        empty;

  // Pipeline / ctrl_mem side
  modport master (
    output rdy, st_valid, st_addr, st_data, st_length,
    output ld_valid, ld_addr, rd_pending, ram_busy, ram_ready,
    input  st_ready, ld_hazard, ram_write, ram_addr, ram_data, ram_length, empty
  );

  // Store buffer side
  modport slave (
    input  rdy, st_valid, st_addr, st_data, st_length,
    input  ld_valid, ld_addr, rd_pending, ram_busy, ram_ready,
    output st_ready, ld_hazard, ram_write, ram_addr, ram_data, ram_length, empty
  );
endinterface

// File: rtl/ctrl_store_buf.sv
// Posted-store buffer: accepts SB/SH/SW from MEM in one cycle, drains them in
// FIFO order to ctrl_mem's write port, and flags loads that must wait for the drain.
module ctrl_store_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input logic             clock,
  input logic             reset,
  ctrl_store_buf_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [2:0]       ent_len  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  state_t           state;

  logic             write_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [2:0]       len_q;

  logic             full;
  logic             push;
  logic             pop;
  logic             is_empty;
  logic             match;
  logic             hazard;
  logic             start;
  logic [PTR_W-1:0] idx;

  // Occupancy, handshake and drain-start decisions
  always_comb begin
    full     = (count == (PTR_W+1)'(DEPTH));
    push     = bus.rdy && bus.st_valid && !full;
    pop      = bus.rdy && (state == S_WAIT) && bus.ram_ready;
    is_empty = (count == '0) && (state == S_IDLE);
    hazard   = bus.ld_valid && !is_empty &&
               ((bus.ld_addr[17:16] == 2'b11) || match);
    start    = (count != '0) && !bus.ram_busy &&
               (!bus.rd_pending || full || hazard);
  end

  // Word-granular overlap of the load against every occupied entry
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (ent_addr[idx][31:2] == bus.ld_addr[31:2]))
        match = 1'b1;
    end
  end

  // Entry storage written at the tail on an accepted store
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      ent_addr[tail] <= bus.st_addr;
      ent_data[tail] <= bus.st_data;
      ent_len[tail]  <= bus.st_length;
    end
  end

  // Pointers, occupancy and drain FSM; everything freezes while rdy is low
  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      state   <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
    end else if (bus.rdy) begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ISSUE;
            write_q <= 1'b1;
            addr_q  <= ent_addr[head];
            data_q  <= ent_data[head];
            len_q   <= ent_len[head];
          end
        end
        S_ISSUE: begin
          state   <= S_WAIT;
          write_q <= 1'b0;
        end
        S_WAIT: begin
          if (bus.ram_ready) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs; the write strobe is masked while rdy is low so a frozen ISSUE
  // cycle is replayed, not lost, once rdy returns
  always_comb begin
    bus.st_ready   = !full;
    bus.ld_hazard  = hazard;
    bus.ram_write  = write_q && bus.rdy;
    bus.ram_addr   = addr_q;
    bus.ram_data   = data_q;
    bus.ram_length = len_q;
    bus.empty      = is_empty;
  end

endmodule

// File: tb/tb_ctrl_store_buf.sv
// Self-checking bench for ctrl_store_buf: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a queue model.
module tb_ctrl_store_buf;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_store_buf_if bus ();

  ctrl_store_buf #(.DEPTH(4), .PTR_W(2)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  l;
  } ent_t;

  ent_t        mq[$];
  int          m_phase = 0;   // 0 nothing in flight, 1 write strobe cycle, 2 awaiting completion
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_len  = '0;
  bit          m_live = 0;
  bit          m_push;
  bit          m_haz;
  ent_t        m_new;

  function automatic bit m_empty();
    return (mq.size() == 0) && (m_phase == 0);
  endfunction

  function automatic bit m_hazard();
    if (!bus.ld_valid || m_empty()) return 0;
    if (bus.ld_addr[17:16] == 2'b11) return 1;
    foreach (mq[i]) if (mq[i].a[31:2] == bus.ld_addr[31:2]) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_phase = 0;
      m_addr  = '0;
      m_data  = '0;
      m_len   = '0;
      m_live  = 1;
    end else if (m_live && bus.rdy) begin
      m_push = bus.st_valid && (mq.size() < DEPTH);
      m_haz  = m_hazard();
      m_new  = '{a: bus.st_addr, d: bus.st_data, l: bus.st_length};
      if (m_phase == 0) begin
        if (mq.size() > 0 && !bus.ram_busy &&
            (!bus.rd_pending || mq.size() == DEPTH || m_haz)) begin
          m_phase = 1;
          m_addr  = mq[0].a;
          m_data  = mq[0].d;
          m_len   = mq[0].l;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (bus.ram_ready) begin
        void'(mq.pop_front());
        m_phase = 0;
      end
      if (m_push) mq.push_back(m_new);
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("st_ready",   {31'b0, bus.st_ready},  {31'b0, mq.size() != DEPTH});
      chk("empty",      {31'b0, bus.empty},     {31'b0, m_empty()});
      chk("ld_hazard",  {31'b0, bus.ld_hazard}, {31'b0, m_hazard()});
      chk("ram_write",  {31'b0, bus.ram_write}, {31'b0, (m_phase == 1) && bus.rdy});
      chk("ram_addr",   bus.ram_addr,           m_addr);
      chk("ram_data",   bus.ram_data,           m_data);
      chk("ram_length", {29'b0, bus.ram_length}, {29'b0, m_len});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    bus.st_valid  = 1'b1;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_length = l;
  endtask

  task automatic wait_write();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.ram_write === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_write_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_all();
    bit ok;
    ok = 0;
    bus.rd_pending = 1'b0;
    bus.ram_ready  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.empty === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    bus.ram_ready = 1'b0;
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] base;

  initial begin
    reset          = 1'b1;
    bus.rdy        = 1'b1;
    bus.st_valid   = 1'b0;
    bus.st_addr    = '0;
    bus.st_data    = '0;
    bus.st_length  = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.rd_pending = 1'b0;
    bus.ram_busy   = 1'b0;
    bus.ram_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_st_ready",  {31'b0, bus.st_ready},  32'd1);
    chk("rst_empty",     {31'b0, bus.empty},     32'd1);
    chk("rst_ram_write", {31'b0, bus.ram_write}, 32'd0);
    chk("rst_ram_addr",  bus.ram_addr,           32'd0);
    chk("rst_ram_len",   {29'b0, bus.ram_length}, 32'd0);

    // Single SW, write strobe two cycles after acceptance
    set_store(32'h100, 32'hDEADBEEF, 3'd4);
    tick();
    bus.st_valid = 1'b0;
    #1;
    chk("sw_no_write_yet", {31'b0, bus.ram_write}, 32'd0);
    chk("sw_not_empty",    {31'b0, bus.empty},     32'd0);
    tick();
    #1;
    chk("sw_write",      {31'b0, bus.ram_write}, 32'd1);
    chk("sw_write_addr", bus.ram_addr,           32'h100);
    chk("sw_write_data", bus.ram_data,           32'hDEADBEEF);
    chk("sw_write_len",  {29'b0, bus.ram_length}, 32'd4);
    tick();
    bus.ram_ready = 1'b1;
    #1;
    chk("sw_wait_no_write", {31'b0, bus.ram_write}, 32'd0);
    chk("sw_wait_hold",     bus.ram_addr,           32'h100);
    tick();
    bus.ram_ready = 1'b0;
    #1;
    chk("sw_empty_after", {31'b0, bus.empty}, 32'd1);

    // Fill to DEPTH while reads are pending; a full buffer drains anyway
    bus.rd_pending = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_store(32'h400 + 32'(4 * k), 32'(k), 3'd4);
      tick();
    end
    bus.st_valid = 1'b0;
    #1;
    chk("full_st_ready", {31'b0, bus.st_ready}, 32'd0);
    tick();
    #1;
    chk("full_drain_write", {31'b0, bus.ram_write}, 32'd1);
    chk("full_drain_addr",  bus.ram_addr,           32'h400);
    tick();
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    #1;
    chk("after_pop_st_ready", {31'b0, bus.st_ready}, 32'd1);
    drain_all();

    // Word-granular overlap hazard; clears as the buffer empties
    bus.rd_pending = 1'b1;
    set_store(32'h203, 32'hAB, 3'd1);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h200;
    #1;
    chk("haz_same_word", {31'b0, bus.ld_hazard}, 32'd1);
    bus.ld_addr = 32'h204;
    #1;
    chk("haz_next_word", {31'b0, bus.ld_hazard}, 32'd0);
    bus.ld_addr = 32'h200;
    drain_all();
    chk("haz_cleared", {31'b0, bus.ld_hazard}, 32'd0);
    bus.ld_valid = 1'b0;

    // I/O-region load hazards only while the buffer is non-empty
    bus.rd_pending = 1'b1;
    set_store(32'h40, 32'h5, 3'd1);
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h30000;
    #1;
    chk("io_haz_busy", {31'b0, bus.ld_hazard}, 32'd1);
    drain_all();
    chk("io_haz_empty", {31'b0, bus.ld_hazard}, 32'd0);
    bus.ld_valid = 1'b0;

    // Push and pop together at count 2 with the tail wrapping
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rd_pending = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_store(32'h500 + 32'(4 * k), 32'h11 * 32'(k + 1), 3'd4);
      tick();
    end
    bus.st_valid   = 1'b0;
    bus.rd_pending = 1'b0;
    wait_write();
    chk("wrap_addr0", bus.ram_addr, 32'h500);
    tick();
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    wait_write();
    chk("wrap_addr1", bus.ram_addr, 32'h504);
    tick();
    bus.ram_ready = 1'b1;
    set_store(32'h50C, 32'h44, 3'd2);
    #1;
    chk("wrap_st_ready", {31'b0, bus.st_ready}, 32'd1);
    tick();
    bus.st_valid  = 1'b0;
    bus.ram_ready = 1'b0;
    wait_write();
    chk("wrap_addr2", bus.ram_addr, 32'h508);
    tick();
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    wait_write();
    chk("wrap_addr3", bus.ram_addr,           32'h50C);
    chk("wrap_len3",  {29'b0, bus.ram_length}, 32'd2);
    chk("wrap_data3", bus.ram_data,           32'h44);
    tick();
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    #1;
    chk("wrap_empty", {31'b0, bus.empty}, 32'd1);

    // rdy low over the ISSUE cycle: strobe suppressed, then replayed once
    set_store(32'h600, 32'h66, 3'd4);
    tick();
    bus.st_valid = 1'b0;
    tick();
    bus.rdy = 1'b0;
    #1;
    chk("frz_no_write", {31'b0, bus.ram_write}, 32'd0);
    chk("frz_addr",     bus.ram_addr,           32'h600);
    tick();
    #1;
    chk("frz_still_no_write", {31'b0, bus.ram_write}, 32'd0);
    bus.rdy = 1'b1;
    #1;
    chk("frz_replay_write", {31'b0, bus.ram_write}, 32'd1);
    chk("frz_replay_data",  bus.ram_data,           32'h66);
    tick();
    #1;
    chk("frz_single_pulse", {31'b0, bus.ram_write}, 32'd0);
    bus.ram_ready = 1'b1;
    tick();
    bus.ram_ready = 1'b0;
    #1;
    chk("frz_empty", {31'b0, bus.empty}, 32'd1);

    // Reset while waiting on ctrl_mem drops the entry
    set_store(32'h700, 32'h77, 3'd4);
    tick();
    bus.st_valid = 1'b0;
    wait_write();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstw_write",    {31'b0, bus.ram_write}, 32'd0);
    chk("rstw_empty",    {31'b0, bus.empty},     32'd1);
    chk("rstw_st_ready", {31'b0, bus.st_ready},  32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(0, 299) == 0);
      bus.rdy        = ($urandom_range(0, 9) != 0);
      bus.st_valid   = ($urandom_range(0, 1) == 0);
      base           = ($urandom_range(0, 3) == 0) ? 32'h0003_0000 : 32'h0000_1000;
      bus.st_addr    = base + 32'($urandom_range(0, 31));
      bus.st_data    = $urandom;
      case ($urandom_range(0, 2))
        0:       bus.st_length = 3'd1;
        1:       bus.st_length = 3'd2;
        default: bus.st_length = 3'd4;
      endcase
      bus.ld_valid   = ($urandom_range(0, 2) == 0);
      base           = ($urandom_range(0, 4) == 0) ? 32'h0003_0000 : 32'h0000_1000;
      bus.ld_addr    = base + 32'($urandom_range(0, 31));
      bus.rd_pending = ($urandom_range(0, 1) == 0);
      bus.ram_busy   = ($urandom_range(0, 3) == 0);
      bus.ram_ready  = ($urandom_range(0, 4) < 2);
      tick();
    end

    reset          = 1'b0;
    bus.rdy        = 1'b1;
    bus.st_valid   = 1'b0;
    bus.ld_valid   = 1'b0;
    drain_all();
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
